// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one radix-2 step per cycle, 32 iterations.
// Divide-by-zero and signed overflow finish in one cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [31:0] ma;
  logic [31:0] mb;
  logic        negq;
  logic        negr;
  logic [63:0] acc;

  logic        is_div;
  logic        s1;
  logic        s2;
  logic        sa;
  logic        sb;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        divz;
  logic        ovf;
  logic        special;
  logic [31:0] spec_res;

  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_df;
  logic [63:0] div_nxt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] remv;
  logic [31:0] mul_res;
  logic [31:0] div_res;
  logic        last;

  // Operand decode at issue: signedness, magnitudes, one-cycle cases.
  always_comb begin
    is_div   = funct3[2];
    s1       = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    s2       = is_div ? ~funct3[0] : ~funct3[1];
    sa       = s1 & rs1_data[31];
    sb       = s2 & rs2_data[31];
    abs1     = sa ? -rs1_data : rs1_data;
    abs2     = sb ? -rs2_data : rs2_data;
    divz     = is_div && (rs2_data == 32'h0);
    ovf      = is_div && !funct3[0] &&
               (rs1_data == 32'h8000_0000) &&
               (rs2_data == 32'hFFFF_FFFF);
    special  = divz | ovf;
    spec_res = divz ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                    : (funct3[1] ? 32'h0 : 32'h8000_0000);
  end

  // One shift-add or restoring-subtract step, plus final sign fixup.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
    mul_nxt = {mul_sum, acc[31:1]};
    div_sh  = {acc[63:32], acc[31]};
    div_ge  = div_sh >= {1'b0, mb};
    div_df  = div_sh[31:0] - mb;
    div_nxt = div_ge ? {div_df, acc[30:0], 1'b1}
                     : {div_sh[31:0], acc[30:0], 1'b0};
    prod    = negq ? -mul_nxt : mul_nxt;
    quo     = negq ? -div_nxt[31:0] : div_nxt[31:0];
    remv    = negr ? -div_nxt[63:32] : div_nxt[63:32];
    mul_res = (op == 2'b00) ? prod[31:0] : prod[63:32];
    div_res = op[1] ? remv : quo;
    last    = (cnt == 5'd31);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!funct3[2])   state_nxt = MUL;
          else if (special) state_nxt = DONE;
          else              state_nxt = DIV;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 5'd0;
      op     <= 2'd0;
      ma     <= 32'd0;
      mb     <= 32'd0;
      negq   <= 1'b0;
      negr   <= 1'b0;
      acc    <= 64'd0;
      result <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op   <= funct3[1:0];
            ma   <= abs1;
            mb   <= abs2;
            negq <= sa ^ sb;
            negr <= sa;
            cnt  <= 5'd0;
            acc  <= is_div ? {32'd0, abs1} : {32'd0, abs2};
            if (special) result <= spec_res;
          end
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 5'd1;
          if (last) result <= mul_res;
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 5'd1;
          if (last) result <= div_res;
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors,
// latency/busy checks, start-ignore and reset-abort scenarios.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", result, 32'hDEAD_BEEF ^ result ^ 32'h1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issue one op; ghost=1 pulses a second start at T+5 that must be ignored.
  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp_res,
                        input int lat,
                        input bit ghost);
    exp_t e;
    int n;
    int bcnt;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    funct3 = f3;
    rs1_data = a;
    rs2_data = b;
    e.res = exp_res;
    e.t0 = cyc;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    n = 0;
    bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      start = (ghost && n == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) chk("timeout", 32'(n), 32'(lat));
    else chk("busy_cycles", 32'(bcnt), (lat == 33) ? 32'd32 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);

    // first start right after reset release is taken normally
    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op(3'b011, 32'h8000_0000, 32'd2,         32'h0000_0001, 33, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        33, 0);
    run_op(3'b111, 32'd100,       32'd7,         32'd2,         33, 0);
    run_op(3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0);
    run_op(3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33, 0);
    run_op(3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 33, 0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 0);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 33, 0);

    // one-cycle special cases
    run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op(3'b111, 32'd5,         32'd0,         32'd5,         1, 0);
    run_op(3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    // a start while busy is dropped: exactly one done
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        33, 1);
    repeat (40) @(negedge clk);
    chk("ghost_no_extra", 32'(sb.size()), 32'd0);

    // reset mid-multiply aborts with no done
    @(negedge clk);
    start = 1'b1;
    funct3 = 3'b000;
    rs1_data = 32'd3;
    rs2_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    // unit still works after the abort
    run_op(3'b000, 32'd3,         32'd5,         32'd15,        33, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: rs1_data  input  XLEN  multiplicand or dividend.
REQ-007 Port: rs2_data  input  XLEN  multiplier or divisor.
REQ-008 Port: busy  output  1  high while an operation is iterating (MUL or DIV state).
REQ-009 Port: done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 Port: result  output  XLEN  registered result.

Function
REQ-011 States SHALL be IDLE, MUL, DIV and DONE, with reset state IDLE.
REQ-012 In IDLE with start=1 (cycle T), the block SHALL latch funct3, rs1_data and rs2_data; later changes on these inputs have no effect.
REQ-013 Transitions: IDLE->MUL if funct3[2]=0; IDLE->DIV if funct3[2]=1 and no special case applies; IDLE->DONE directly on a special case (REQ-019/020).
REQ-014 MUL/DIV SHALL run exactly 32 iterations via a 5-bit counter; busy=1 in cycles T+1..T+32; DONE in cycle T+33; IDLE in T+34.
REQ-015 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE; start in MUL, DIV or DONE SHALL be ignored (no queuing).
REQ-016 Multiply: signed operands SHALL be converted to magnitudes (rs1 signed for MUL/MULH/MULHSU; rs2 signed for MUL/MULH only), then one radix-2 shift-add step per cycle on a 64-bit accumulator, and the 64-bit product SHALL be negated when the operand signs differ.
REQ-017 Multiply result selection: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32].
REQ-018 Divide: restoring algorithm on magnitudes (signed for DIV/REM), one quotient bit per cycle; quotient sign = XOR of operand signs; remainder sign = dividend sign; DIV/DIVU return the quotient, REM/REMU the remainder.
REQ-019 Divisor zero: DIV/DIVU SHALL return 0xFFFFFFFF and REM/REMU SHALL return rs1_data, with done at T+1.
REQ-020 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM 0x00000000, with done at T+1.
REQ-021 result SHALL update only on entry to DONE and hold its value until the next DONE; result is undefined-free (never X) after reset.
REQ-022 done and busy SHALL never both be 1, and start accepted in the same cycle the block enters IDLE from DONE is impossible (start is sampled only while in IDLE).

Reset
REQ-023 On reset=1 at a clock edge: state IDLE, busy=0, done=0, result=0, counter=0, latched operands=0.
REQ-024 Reset SHALL override start and any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-025 start sampled in the first cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-026 MUL rs1=7, rs2=0xFFFFFFFD at T -> busy T+1..T+32, done at T+33 with result=0xFFFFFFEB.
REQ-027 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF, 2 -> 0xFFFFFFFF.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done at T+33.
REQ-029 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done at T+1 and busy never high; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each with done at T+1.
REQ-030 Assert reset at T+10 of a MUL -> busy=0 and result=0 next cycle, no done within 40 cycles; a start pulsed at T+5 of a normal op is ignored, yielding exactly one done.
